// File: rtl/param_ring_counter.sv
// Parametrised ring / Johnson shift counter with direction, preset, parallel load,
// wrap pulse and illegal-state flag. Optional repair of illegal states: RING_SELF_CORRECT_EN.
module param_ring_counter #(
  parameter int WIDTH = 4,
  parameter int INIT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RING_HOME = WIDTH'(INIT);

  // INIT must be a single set bit that fits inside the counter
  if (WIDTH < 2 || INIT <= 0 || (INIT & (INIT - 1)) != 0 || (64'(INIT) >> WIDTH) != 64'd0)
  begin : g_bad_param
    $error("param_ring_counter: WIDTH must be >= 2 and INIT one-hot within WIDTH bits");
  end

  function automatic logic [WIDTH-1:0] home_of(input logic m);
    return m ? '0 : RING_HOME;
  endfunction

  function automatic logic [WIDTH-1:0] step_of(input logic [WIDTH-1:0] v,
                                               input logic m, input logic d);
    logic [WIDTH-1:0] r;
    if (!d) r = {v[WIDTH-2:0], v[WIDTH-1] ^ m};
    else    r = {v[0] ^ m, v[WIDTH-1:1]};
    return r;
  endfunction

  // Johnson legality: a single cyclic run of ones has 0 or 2 bit transitions
  function automatic logic is_illegal(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-1:0] edges;
    edges = v ^ {v[0], v[WIDTH-1:1]};
    if (!m) return $countones(v) != 1;
    return !($countones(edges) == 0 || $countones(edges) == 2);
  endfunction

  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] nxt;

  assign home = home_of(mode);
  assign nxt  = step_of(q, mode, dir);
  assign err  = is_illegal(q, mode);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= RING_HOME;
      wrap <= 1'b0;
    end else if (preset) begin
      q    <= home;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
      if (err) begin
        q    <= home;
        wrap <= 1'b1;
      end else begin
        q    <= nxt;
        wrap <= (nxt == home);
      end
`else
      q    <= nxt;
      wrap <= (nxt == home);
`endif
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_ring_counter.sv
// Bench for param_ring_counter: directed sequences plus randomized traffic on a 4-bit
// and an 8-bit instance, checked against an index-based behavioural model.
module tb_param_ring_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, preset = 1'b0, load = 1'b0, mode = 1'b0, dir = 1'b0;
  logic [3:0] load_val4 = '0;
  logic [7:0] load_val8 = '0;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       wrap4, wrap8, err4, err8;

  int nchecks = 0;
  int nerrors = 0;
  logic [7:0] mq4, mq8;
  logic       mw4, mw8;
  int         wc;

  always #5 clk = ~clk;

  param_ring_counter #(.WIDTH(4), .INIT(1)) dut4 (
    .clk(clk), .reset(reset), .en(en), .preset(preset), .load(load),
    .load_val(load_val4), .mode(mode), .dir(dir), .q(q4), .wrap(wrap4), .err(err4));

  param_ring_counter #(.WIDTH(8), .INIT(1)) dut8 (
    .clk(clk), .reset(reset), .en(en), .preset(preset), .load(load),
    .load_val(load_val8), .mode(mode), .dir(dir), .q(q8), .wrap(wrap8), .err(err8));

  function automatic logic m_err(input int w, input logic [7:0] v, input logic md);
    int cnt;
    cnt = 0;
    for (int i = 0; i < w; i++) begin
      if (!md) cnt += int'(v[i]);
      else if (v[i] != v[(i + 1) % w]) cnt++;
    end
    if (!md) return cnt != 1;
    return !(cnt == 0 || cnt == 2);
  endfunction

  function automatic logic [7:0] m_shift(input int w, input logic [7:0] v,
                                         input logic md, input logic d);
    logic [7:0] r;
    logic       b;
    r = '0;
    for (int i = 0; i < w; i++) begin
      b = d ? v[(i + 1) % w] : v[(i + w - 1) % w];
      if (md && ((!d && i == 0) || (d && i == w - 1))) b = ~b;
      r[i] = b;
    end
    return r;
  endfunction

  function automatic logic [8:0] m_next(input int w, input logic [7:0] v, input logic [7:0] lv,
                                        input logic pr, input logic ld, input logic e,
                                        input logic md, input logic d);
    logic [7:0] hm, nv, mask;
    mask = 8'((1 << w) - 1);
    hm   = md ? 8'h00 : 8'h01;
    if (pr) return {1'b0, hm};
    if (ld) return {1'b0, lv & mask};
    if (e) begin
`ifdef RING_SELF_CORRECT_EN
      if (m_err(w, v, md)) return {1'b1, hm};
`endif
      nv = m_shift(w, v, md, d);
      return {nv == hm, nv};
    end
    return {1'b0, v};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    {mw4, mq4} = m_next(4, mq4, {4'b0, load_val4}, preset, load, en, mode, dir);
    {mw8, mq8} = m_next(8, mq8, load_val8, preset, load, en, mode, dir);
    @(negedge clk);
    chk("q4",    {4'b0, q4},    mq4);
    chk("wrap4", {7'b0, wrap4}, {7'b0, mw4});
    chk("err4",  {7'b0, err4},  {7'b0, m_err(4, mq4, mode)});
    chk("q8",    q8,            mq8);
    chk("wrap8", {7'b0, wrap8}, {7'b0, mw8});
    chk("err8",  {7'b0, err8},  {7'b0, m_err(8, mq8, mode)});
  endtask

  // Reset asserted mid-cycle, away from both clock edges
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    mq4 = 8'h01; mq8 = 8'h01; mw4 = 1'b0; mw8 = 1'b0;
    chk("rst_q4",    {4'b0, q4},    8'h01);
    chk("rst_wrap4", {7'b0, wrap4}, 8'h00);
    chk("rst_q8",    q8,            8'h01);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [3:0] seq1 [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] seq2 [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] seq3 [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                           4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    mq4 = 8'h01; mq8 = 8'h01; mw4 = 1'b0; mw8 = 1'b0;
    async_reset();

    // 1: ring, left
    en = 1'b1; mode = 1'b0; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_q", {4'b0, q4}, {4'b0, seq1[i]});
      chk("t1_wrap", {7'b0, wrap4}, (i == 3) ? 8'h01 : 8'h00);
    end

    // 2: ring, right
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_q", {4'b0, q4}, {4'b0, seq2[i]});
      chk("t2_wrap", {7'b0, wrap4}, (i == 3) ? 8'h01 : 8'h00);
    end

    // 3: Johnson, left
    mode = 1'b1; preset = 1'b1; en = 1'b0; dir = 1'b0;
    tick();
    chk("t3_preset", {4'b0, q4}, 8'h00);
    preset = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_q", {4'b0, q4}, {4'b0, seq3[i]});
      chk("t3_wrap", {7'b0, wrap4}, (i == 7) ? 8'h01 : 8'h00);
    end

    // 4: illegal load in ring mode
    mode = 1'b0; en = 1'b0; load = 1'b1; load_val4 = 4'b0101; load_val8 = 8'h01;
    tick();
    chk("t4_load_q", {4'b0, q4}, 8'h05);
    chk("t4_load_err", {7'b0, err4}, 8'h01);
    load = 1'b0; en = 1'b1;
    tick();
`ifdef RING_SELF_CORRECT_EN
    chk("t4_fix_q", {4'b0, q4}, 8'h01);
    chk("t4_fix_wrap", {7'b0, wrap4}, 8'h01);
`else
    chk("t4_step_q", {4'b0, q4}, 8'h0A);
    chk("t4_step_err", {7'b0, err4}, 8'h01);
`endif

    // 5: preset beats load, hold, async reset
    preset = 1'b1; load = 1'b1; load_val4 = 4'b0100; en = 1'b0;
    tick();
    chk("t5_pri_q", {4'b0, q4}, 8'h01);
    preset = 1'b0; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_q", {4'b0, q4}, 8'h01);
      chk("t5_hold_wrap", {7'b0, wrap4}, 8'h00);
    end
    en = 1'b1;
    tick();
    chk("t5_pre_rst_q", {4'b0, q4}, 8'h02);
    async_reset();

    // 6: 8-bit ring and Johnson cycle lengths
    mode = 1'b0; preset = 1'b1; en = 1'b0; dir = 1'b0;
    tick();
    preset = 1'b0; en = 1'b1; wc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      wc += int'(wrap8);
    end
    chk("t6_ring_q", q8, 8'h01);
    chk("t6_ring_wraps", 8'(wc), 8'd1);
    mode = 1'b1; preset = 1'b1; en = 1'b0;
    tick();
    preset = 1'b0; en = 1'b1; wc = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      wc += int'(wrap8);
    end
    chk("t6_john_q", q8, 8'h00);
    chk("t6_john_wraps", 8'(wc), 8'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      en        = ($urandom_range(0, 3) != 0);
      preset    = ($urandom_range(0, 15) == 0);
      load      = ($urandom_range(0, 9) == 0);
      load_val4 = 4'($urandom);
      load_val8 = 8'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 49) == 0) async_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
